// File: rtl/shift_seq_ctrl.sv
// Two-requester controller for a shared N-bit bidirectional serial shift register.
// Optional macro SHIFT_SEQ_CTRL_RR_EN selects round-robin arbitration (default: fixed priority, requester 0 first).
module shift_seq_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic         dir0,
    input  logic         dir1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic [N-1:0] rdata,
    output logic         sr_data,
    output logic         sr_mode,
    output logic         sr_en,
    input  logic         sr_q
);

    localparam int unsigned CW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]  r_buf, w_buf_nxt;
    logic [N-1:0]  r_cap, w_cap_nxt;
    logic [N-1:0]  r_rdata, w_rdata_nxt;
    logic [1:0]    r_gnt, w_gnt_nxt;
    logic          r_busy, r_done, w_done_nxt;
    logic          r_done_id, w_done_id_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_mode, w_mode_nxt;
    logic          r_data, w_data_nxt;
    logic          r_en, w_en_nxt;

    logic          w_win;
    logic          w_wdir;
    logic [N-1:0]  w_word;
    logic [N-1:0]  w_cap_sh;

`ifdef SHIFT_SEQ_CTRL_RR_EN
    // r_ptr is the last granted requester; on contention the other one wins
    logic r_ptr;

    assign w_win = (req == 2'b11) ? ~r_ptr : req[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b1;
        end else if (r_state == S_IDLE && |req) begin
            r_ptr <= w_win;
        end
    end
`else
    assign w_win = ~req[0];
`endif

    assign w_word   = w_win ? wdata1 : wdata0;
    assign w_wdir   = w_win ? dir1 : dir0;
    // Shifted-out bit enters from the end opposite to where it leaves the register
    assign w_cap_sh = r_mode ? {sr_q, r_cap[N-1:1]} : {r_cap[N-2:0], sr_q};

    // State register and all output/datapath flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_buf     <= '0;
            r_cap     <= '0;
            r_rdata   <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_owner   <= 1'b0;
            r_mode    <= 1'b0;
            r_data    <= 1'b0;
            r_en      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_buf     <= w_buf_nxt;
            r_cap     <= w_cap_nxt;
            r_rdata   <= w_rdata_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_owner   <= w_owner_nxt;
            r_mode    <= w_mode_nxt;
            r_data    <= w_data_nxt;
            r_en      <= w_en_nxt;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_buf_nxt     = r_buf;
        w_cap_nxt     = r_cap;
        w_rdata_nxt   = r_rdata;
        w_gnt_nxt     = 2'b00;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_owner_nxt   = r_owner;
        w_mode_nxt    = r_mode;
        w_data_nxt    = 1'b0;
        w_en_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_owner_nxt = w_win;
                    w_mode_nxt  = w_wdir;
                    w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
                    w_en_nxt    = 1'b1;
                    w_data_nxt  = w_wdir ? w_word[0] : w_word[N-1];
                    w_buf_nxt   = w_wdir ? {1'b0, w_word[N-1:1]} : {w_word[N-2:0], 1'b0};
                end
            end
            S_SHIFT: begin
                w_cap_nxt = w_cap_sh;
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_rdata_nxt   = w_cap_sh;
                    w_done_id_nxt = r_owner;
                end else begin
                    w_cnt_nxt  = r_cnt + CW'(1);
                    w_en_nxt   = 1'b1;
                    w_data_nxt = r_mode ? r_buf[0] : r_buf[N-1];
                    w_buf_nxt  = r_mode ? {1'b0, r_buf[N-1:1]} : {r_buf[N-2:0], 1'b0};
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign rdata   = r_rdata;
    assign sr_data = r_data;
    assign sr_mode = r_mode;
    assign sr_en   = r_en;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural model of the shared shift register.
// Expectations follow SHIFT_SEQ_CTRL_RR_EN when the bench is built with it defined.
module tb_shift_seq_ctrl;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req = 2'b00;
    logic         dir0 = 1'b0, dir1 = 1'b0;
    logic [N-1:0] wdata0 = '0, wdata1 = '0;
    logic [1:0]   gnt;
    logic         busy, done, done_id;
    logic [N-1:0] rdata;
    logic         sr_data, sr_mode, sr_en, sr_q;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    shift_seq_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .dir0(dir0), .dir1(dir1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .busy(busy), .done(done),
        .done_id(done_id), .rdata(rdata), .sr_data(sr_data), .sr_mode(sr_mode),
        .sr_en(sr_en), .sr_q(sr_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared bidirectional shift register model
    logic [N-1:0] mdl = '0;
    logic [N-1:0] mdl_val = '0;
    logic         mdl_load = 1'b0;

    assign sr_q = sr_mode ? mdl[0] : mdl[N-1];

    always @(posedge clk) begin
        if (mdl_load)
            mdl <= mdl_val;
        else if (sr_en)
            mdl <= sr_mode ? {sr_data, mdl[N-1:1]} : {mdl[N-2:0], sr_data};
    end

    task automatic load_mdl(input logic [N-1:0] v);
        @(negedge clk);
        mdl_val  = v;
        mdl_load = 1'b1;
        @(negedge clk);
        mdl_load = 1'b0;
    endtask

    // Runs one frame from an IDLE negedge and reports what was observed
    task automatic do_frame(
        input  logic [1:0]   rq,
        input  logic [1:0]   mid,
        input  bit           hold,
        input  logic         d0,
        input  logic         d1,
        input  logic [N-1:0] w0,
        input  logic [N-1:0] w1,
        output logic [1:0]   o_gnt,
        output int           o_gnt_cnt,
        output int           o_gnt_cyc,
        output logic [N-1:0] o_bits,
        output int           o_en_cnt,
        output int           o_busy_cnt,
        output int           o_done_cyc,
        output logic [N-1:0] o_rdata,
        output logic         o_id,
        output logic         o_mode,
        output logic         o_stray
    );
        o_gnt = 2'b00; o_gnt_cnt = 0; o_gnt_cyc = 0; o_bits = '0; o_en_cnt = 0;
        o_busy_cnt = 0; o_done_cyc = 0; o_rdata = '0; o_id = 1'b0; o_mode = 1'b0; o_stray = 1'b0;
        dir0 = d0; dir1 = d1; wdata0 = w0; wdata1 = w1; req = rq;
        for (int k = 1; k <= 12 && o_done_cyc == 0; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                o_gnt_cnt++;
                if (o_gnt_cnt == 1) begin
                    o_gnt = gnt;
                    o_gnt_cyc = cyc;
                end
                if (!hold) req = mid;
            end
            if (sr_en) begin
                o_bits = {sr_data, o_bits[N-1:1]};
                o_en_cnt++;
                o_mode = sr_mode;
            end else if (sr_data) begin
                o_stray = 1'b1;
            end
            if (busy) o_busy_cnt++;
            if (done) begin
                o_done_cyc = k;
                o_rdata = rdata;
                o_id = done_id;
            end
            if (k == N && !hold) req = 2'b00;
        end
        @(negedge clk);
        if (gnt != 2'b00) o_gnt_cnt++;
        if (sr_data || sr_en || busy) o_stray = 1'b1;
    endtask

    logic [1:0]   f_gnt;
    int           f_gcnt, f_gcyc, f_en, f_busy, f_dcyc;
    logic [N-1:0] f_bits, f_rdata;
    logic         f_id, f_mode, f_stray;

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({gnt, busy, done, done_id, sr_data, sr_mode, sr_en} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {gnt, busy, done, done_id, sr_data, sr_mode, sr_en});
        end
        vecs++;
        if (rdata !== 4'b0000) begin
            errs++;
            $display("FAIL reset_rdata: got %b expected 0000", rdata);
        end
        rst = 1'b1;
        load_mdl(4'b0000);
    endtask

    task automatic test_basic();
        do_frame(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000,
                 f_gnt, f_gcnt, f_gcyc, f_bits, f_en, f_busy, f_dcyc, f_rdata, f_id, f_mode, f_stray);
        vecs++; if (f_gnt !== 2'b01) begin errs++; $display("FAIL a_gnt: got %b expected 01", f_gnt); end
        vecs++; if (f_gcnt !== 1) begin errs++; $display("FAIL a_gnt_cnt: got %0d expected 1", f_gcnt); end
        vecs++; if (f_bits !== 4'b1010) begin errs++; $display("FAIL a_bits: got %b expected 1010", f_bits); end
        vecs++; if (f_en !== 4) begin errs++; $display("FAIL a_en_cnt: got %0d expected 4", f_en); end
        vecs++; if (f_busy !== 5) begin errs++; $display("FAIL a_busy_cnt: got %0d expected 5", f_busy); end
        vecs++; if (f_dcyc !== 5) begin errs++; $display("FAIL a_done_cyc: got %0d expected 5", f_dcyc); end
        vecs++; if (f_rdata !== 4'b0000) begin errs++; $display("FAIL a_rdata: got %b expected 0000", f_rdata); end
        vecs++; if (f_id !== 1'b0) begin errs++; $display("FAIL a_id: got %b expected 0", f_id); end
        vecs++; if (f_mode !== 1'b1) begin errs++; $display("FAIL a_mode: got %b expected 1", f_mode); end
        vecs++; if (f_stray !== 1'b0) begin errs++; $display("FAIL a_stray: got %b expected 0", f_stray); end
        vecs++; if (mdl !== 4'b1010) begin errs++; $display("FAIL a_reg: got %b expected 1010", mdl); end
        vecs++; if (sr_mode !== 1'b1) begin errs++; $display("FAIL a_mode_hold: got %b expected 1", sr_mode); end

        do_frame(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0110,
                 f_gnt, f_gcnt, f_gcyc, f_bits, f_en, f_busy, f_dcyc, f_rdata, f_id, f_mode, f_stray);
        vecs++; if (f_gnt !== 2'b10) begin errs++; $display("FAIL b_gnt: got %b expected 10", f_gnt); end
        vecs++; if (f_mode !== 1'b0) begin errs++; $display("FAIL b_mode: got %b expected 0", f_mode); end
        vecs++; if (f_bits !== 4'b0110) begin errs++; $display("FAIL b_bits: got %b expected 0110", f_bits); end
        vecs++; if (f_dcyc !== 5) begin errs++; $display("FAIL b_done_cyc: got %0d expected 5", f_dcyc); end
        vecs++; if (f_rdata !== 4'b1010) begin errs++; $display("FAIL b_rdata: got %b expected 1010", f_rdata); end
        vecs++; if (f_id !== 1'b1) begin errs++; $display("FAIL b_id: got %b expected 1", f_id); end
        vecs++; if (mdl !== 4'b0110) begin errs++; $display("FAIL b_reg: got %b expected 0110", mdl); end
        vecs++; if (rdata !== 4'b1010) begin errs++; $display("FAIL b_rdata_hold: got %b expected 1010", rdata); end
    endtask

    task automatic test_arbitration();
        logic [1:0]   exp_g [3];
        logic [N-1:0] exp_r [3];
`ifdef SHIFT_SEQ_CTRL_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01};
        exp_r = '{4'b0110, 4'b0011, 4'b1100};
`else
        exp_g = '{2'b01, 2'b01, 2'b01};
        exp_r = '{4'b0110, 4'b0011, 4'b0011};
`endif
        for (int f = 0; f < 3; f++) begin
            do_frame(2'b11, 2'b00, (f < 2), 1'b1, 1'b0, 4'b0011, 4'b1100,
                     f_gnt, f_gcnt, f_gcyc, f_bits, f_en, f_busy, f_dcyc, f_rdata, f_id, f_mode, f_stray);
            vecs++;
            if (f_gnt !== exp_g[f]) begin
                errs++; $display("FAIL arb_gnt%0d: got %b expected %b", f, f_gnt, exp_g[f]);
            end
            vecs++;
            if (f_rdata !== exp_r[f] || f_dcyc !== 5) begin
                errs++; $display("FAIL arb_rdata%0d: got %b/%0d expected %b/5", f, f_rdata, f_dcyc, exp_r[f]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        do_frame(2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1001,
                 f_gnt, f_gcnt, f_gcyc, f_bits, f_en, f_busy, f_dcyc, f_rdata, f_id, f_mode, f_stray);
        vecs++; if (f_gcnt !== 1) begin errs++; $display("FAIL ign_gnt_cnt: got %0d expected 1", f_gcnt); end
        vecs++; if (f_gnt !== 2'b10) begin errs++; $display("FAIL ign_gnt: got %b expected 10", f_gnt); end
        vecs++; if (f_bits !== 4'b1001) begin errs++; $display("FAIL ign_bits: got %b expected 1001", f_bits); end
        vecs++; if (f_rdata !== 4'b0011 || f_id !== 1'b1) begin
            errs++; $display("FAIL ign_rdata: got %b/%b expected 0011/1", f_rdata, f_id);
        end
        vecs++; if (f_stray !== 1'b0) begin errs++; $display("FAIL ign_stray: got %b expected 0", f_stray); end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        dir0 = 1'b1; wdata0 = 4'b0101; req = 2'b01;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        req = 2'b00;
        vecs++;
        if ({gnt, busy, done, done_id, sr_data, sr_mode, sr_en} !== 7'b0 || rdata !== 4'b0000) begin
            errs++;
            $display("FAIL rstmid_outs: got %b/%b expected 0000000/0000", {gnt, busy, done, done_id, sr_data, sr_mode, sr_en}, rdata);
        end
        saw_done = 1'b0;
        load_mdl(4'b1110);
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        vecs++; if (saw_done !== 1'b0) begin errs++; $display("FAIL rstmid_no_done: got %b expected 0", saw_done); end
        do_frame(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000,
                 f_gnt, f_gcnt, f_gcyc, f_bits, f_en, f_busy, f_dcyc, f_rdata, f_id, f_mode, f_stray);
        vecs++; if (f_gnt !== 2'b01 || f_dcyc !== 5) begin
            errs++; $display("FAIL rstmid_frame: got %b/%0d expected 01/5", f_gnt, f_dcyc);
        end
        vecs++; if (f_bits !== 4'b1000) begin errs++; $display("FAIL rstmid_bits: got %b expected 1000", f_bits); end
        vecs++; if (f_rdata !== 4'b1110) begin errs++; $display("FAIL rstmid_rdata: got %b expected 1110", f_rdata); end
        vecs++; if (mdl !== 4'b0001) begin errs++; $display("FAIL rstmid_reg: got %b expected 0001", mdl); end
    endtask

    task automatic test_back_to_back();
        int c1;
        do_frame(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 4'b1011, 4'b0000,
                 f_gnt, f_gcnt, f_gcyc, f_bits, f_en, f_busy, f_dcyc, f_rdata, f_id, f_mode, f_stray);
        c1 = f_gcyc;
        vecs++; if (f_rdata !== 4'b0001 || f_gcnt !== 1) begin
            errs++; $display("FAIL b2b_first: got %b/%0d expected 0001/1", f_rdata, f_gcnt);
        end
        do_frame(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1011, 4'b0000,
                 f_gnt, f_gcnt, f_gcyc, f_bits, f_en, f_busy, f_dcyc, f_rdata, f_id, f_mode, f_stray);
        vecs++; if (f_gcyc - c1 !== N + 2) begin
            errs++; $display("FAIL b2b_period: got %0d expected %0d", f_gcyc - c1, N + 2);
        end
        vecs++; if (f_rdata !== 4'b1011 || f_dcyc !== 5) begin
            errs++; $display("FAIL b2b_second: got %b/%0d expected 1011/5", f_rdata, f_dcyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
